// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Brief    : Load-use stall, branch/jump flush and memory-freeze control for
//            a five-stage pipeline, with saturating event counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           ID_Rs,
  input  logic [4:0]           ID_Rt,
  input  logic                 ID_UsesRt,
  input  logic                 EX_MemRead,
  input  logic [4:0]           EX_WriteRegister,
  input  logic                 MEM_BranchTaken,
  input  logic                 WB_Jump,
  input  logic                 MemBusy,
  input  logic                 ClearCounters,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Flush,
  output logic                 EX_MEM_Flush,
  output logic                 MEM_WB_Flush,
  output logic                 Freeze,
  output logic [1:0]           State,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount,
  output logic [CNT_WIDTH-1:0] FreezeCount
);

  localparam logic [1:0] c_S_RUN    = 2'd0;
  localparam logic [1:0] c_S_STALL  = 2'd1;
  localparam logic [1:0] c_S_FLUSH  = 2'd2;
  localparam logic [1:0] c_S_FREEZE = 2'd3;

  localparam logic [2:0] c_A_NONE   = 3'd0;
  localparam logic [2:0] c_A_FREEZE = 3'd1;
  localparam logic [2:0] c_A_JUMP   = 3'd2;
  localparam logic [2:0] c_A_BRANCH = 3'd3;
  localparam logic [2:0] c_A_STALL  = 3'd4;

  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [1:0]           w_nextState;
  logic [2:0]           w_action;
  logic                 w_loadUse;
  logic [CNT_WIDTH-1:0] r_stallCount;
  logic [CNT_WIDTH-1:0] r_flushCount;
  logic [CNT_WIDTH-1:0] r_freezeCount;

  // Load-use detection is masked during the single bubble cycle after a stall or redirect
  assign w_loadUse = EX_MemRead && (EX_WriteRegister != 5'd0) &&
                     ((EX_WriteRegister == ID_Rs) ||
                      (ID_UsesRt && (EX_WriteRegister == ID_Rt))) &&
                     (r_state != c_S_STALL) && (r_state != c_S_FLUSH);

  always_comb begin
    w_action = c_A_NONE;
    if (MemBusy)              w_action = c_A_FREEZE;
    else if (WB_Jump)         w_action = c_A_JUMP;
    else if (MEM_BranchTaken) w_action = c_A_BRANCH;
    else if (w_loadUse)       w_action = c_A_STALL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_S_RUN;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = c_S_RUN;
    case (w_action)
      c_A_FREEZE:           w_nextState = c_S_FREEZE;
      c_A_JUMP, c_A_BRANCH: w_nextState = c_S_FLUSH;
      c_A_STALL:            w_nextState = c_S_STALL;
      default:              w_nextState = c_S_RUN;
    endcase
  end

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    MEM_WB_Flush = 1'b0;
    Freeze       = 1'b0;
    if (!reset) begin
      // Hold the PC and bubble every stage while reset is asserted
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else begin
      case (w_action)
        c_A_FREEZE: begin
          Freeze      = 1'b1;
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
        end
        c_A_JUMP: begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Flush  = 1'b1;
          EX_MEM_Flush = 1'b1;
          MEM_WB_Flush = 1'b1;
        end
        c_A_BRANCH: begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Flush  = 1'b1;
          EX_MEM_Flush = 1'b1;
        end
        c_A_STALL: begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stallCount  <= '0;
      r_flushCount  <= '0;
      r_freezeCount <= '0;
    end else if (ClearCounters) begin
      r_stallCount  <= '0;
      r_flushCount  <= '0;
      r_freezeCount <= '0;
    end else begin
      if ((w_action == c_A_STALL) && (r_stallCount != c_CNT_MAX))
        r_stallCount <= r_stallCount + c_CNT_ONE;
      if (((w_action == c_A_JUMP) || (w_action == c_A_BRANCH)) && (r_flushCount != c_CNT_MAX))
        r_flushCount <= r_flushCount + c_CNT_ONE;
      if ((w_action == c_A_FREEZE) && (r_freezeCount != c_CNT_MAX))
        r_freezeCount <= r_freezeCount + c_CNT_ONE;
    end
  end

  assign State       = r_state;
  assign StallCount  = r_stallCount;
  assign FlushCount  = r_flushCount;
  assign FreezeCount = r_freezeCount;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Brief    : Directed bench for pipeline_hazard_controller (16-bit and 2-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteRegister;
  logic        ID_UsesRt, EX_MemRead, MEM_BranchTaken, WB_Jump, MemBusy, ClearCounters;

  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush, Freeze;
  logic [1:0]  State;
  logic [15:0] StallCount, FlushCount, FreezeCount;

  logic        s_PCWrite, s_IF_ID_Write, s_IF_ID_Flush, s_ID_EX_Flush, s_EX_MEM_Flush, s_MEM_WB_Flush, s_Freeze;
  logic [1:0]  s_State;
  logic [1:0]  s_StallCount, s_FlushCount, s_FreezeCount;

  int r_checks = 0;
  int r_fails  = 0;

  pipeline_hazard_controller dut (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
    .MEM_BranchTaken(MEM_BranchTaken), .WB_Jump(WB_Jump), .MemBusy(MemBusy),
    .ClearCounters(ClearCounters), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
    .MEM_WB_Flush(MEM_WB_Flush), .Freeze(Freeze), .State(State),
    .StallCount(StallCount), .FlushCount(FlushCount), .FreezeCount(FreezeCount)
  );

  pipeline_hazard_controller #(.CNT_WIDTH(2)) dutSmall (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
    .MEM_BranchTaken(MEM_BranchTaken), .WB_Jump(WB_Jump), .MemBusy(MemBusy),
    .ClearCounters(ClearCounters), .PCWrite(s_PCWrite), .IF_ID_Write(s_IF_ID_Write),
    .IF_ID_Flush(s_IF_ID_Flush), .ID_EX_Flush(s_ID_EX_Flush), .EX_MEM_Flush(s_EX_MEM_Flush),
    .MEM_WB_Flush(s_MEM_WB_Flush), .Freeze(s_Freeze), .State(s_State),
    .StallCount(s_StallCount), .FlushCount(s_FlushCount), .FreezeCount(s_FreezeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {PCWrite, IF_ID_Write, Freeze, IF, ID, EX, MEM flushes}
  function automatic logic [31:0] ctl();
    return 32'({PCWrite, IF_ID_Write, Freeze, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; EX_MemRead = 1'b0;
    EX_WriteRegister = 5'd0; MEM_BranchTaken = 1'b0; WB_Jump = 1'b0;
    MemBusy = 1'b0; ClearCounters = 1'b0;
  endtask

  task automatic loadUse(input logic [4:0] rd);
    EX_MemRead = 1'b1; EX_WriteRegister = rd; ID_Rs = rd;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #2;
    chk("reset_ctl", ctl(), 32'b0001111);
    chk("reset_state", 32'(State), 0);
    chk("reset_counts", 32'({StallCount, FlushCount, FreezeCount}), 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("run_idle_ctl", ctl(), 32'b1100000);

    // Load-use on rs
    tick();
    loadUse(5'd8); #1;
    chk("loaduse_ctl", ctl(), 32'b0000100);
    tick();
    chk("loaduse_state", 32'(State), 1);
    chk("loaduse_count", 32'(StallCount), 1);
    chk("stall_suppressed_ctl", ctl(), 32'b1100000);
    idle(); tick();
    chk("stall_one_cycle", 32'(State), 0);

    // rt gating and r0
    EX_MemRead = 1'b1; EX_WriteRegister = 5'd9; ID_Rt = 5'd9; ID_Rs = 5'd1; #1;
    chk("rt_unused_ctl", 32'(PCWrite), 1);
    ID_UsesRt = 1'b1; #1;
    chk("rt_used_ctl", 32'(PCWrite), 0);
    tick();
    chk("rt_used_count", 32'(StallCount), 2);
    idle(); tick();
    EX_MemRead = 1'b1; EX_WriteRegister = 5'd0; ID_Rs = 5'd0; ID_UsesRt = 1'b1; #1;
    chk("r0_ctl", 32'(PCWrite), 1);
    tick();
    chk("r0_count", 32'(StallCount), 2);
    chk("r0_state", 32'(State), 0);

    // Clear
    idle(); ClearCounters = 1'b1; tick();
    chk("clear_count", 32'(StallCount), 0);
    idle();

    // Branch with load-use hazard
    loadUse(5'd8); MEM_BranchTaken = 1'b1; #1;
    chk("branch_ctl", ctl(), 32'b1101110);
    tick();
    chk("branch_state", 32'(State), 2);
    chk("branch_flushcount", 32'(FlushCount), 1);
    chk("branch_stallcount", 32'(StallCount), 0);
    idle(); #1;
    chk("flush_idle_ctl", ctl(), 32'b1100000);
    tick();
    chk("flush_one_cycle", 32'(State), 0);

    // Jump and branch together
    WB_Jump = 1'b1; MEM_BranchTaken = 1'b1; #1;
    chk("jump_ctl", ctl(), 32'b1101111);
    tick();
    chk("jump_flushcount", 32'(FlushCount), 2);
    idle(); tick();

    // Freeze defers the jump
    MemBusy = 1'b1; WB_Jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("freeze_ctl", ctl(), 32'b0010000);
      tick();
    end
    chk("freeze_count", 32'(FreezeCount), 3);
    chk("freeze_state", 32'(State), 3);
    MemBusy = 1'b0; #1;
    chk("deferred_jump_ctl", ctl(), 32'b1101111);
    tick();
    chk("deferred_jump_state", 32'(State), 2);
    chk("deferred_flushcount", 32'(FlushCount), 3);
    chk("small_flushcount", 32'(s_FlushCount), 3);
    idle(); tick();

    // Saturation of the 2-bit counters
    ClearCounters = 1'b1; tick(); idle();
    for (int i = 0; i < 5; i++) begin
      loadUse(5'd12); tick();
      idle(); tick();
    end
    chk("sat_small_stall", 32'(s_StallCount), 3);
    chk("sat_wide_stall", 32'(StallCount), 5);
    loadUse(5'd12); ClearCounters = 1'b1; tick();
    chk("clear_prio_small", 32'(s_StallCount), 0);
    chk("clear_prio_wide", 32'(StallCount), 0);
    chk("clear_prio_state", 32'(State), 1);
    idle(); tick();

    // Asynchronous reset in the middle of a freeze
    MemBusy = 1'b1; tick(); tick();
    chk("prereset_state", 32'(State), 3);
    chk("prereset_freeze", 32'(FreezeCount), 2);
    #2; reset = 1'b0; #1;
    chk("async_state", 32'(State), 0);
    chk("async_counts", 32'({StallCount, FlushCount, FreezeCount}), 0);
    chk("async_small_freeze", 32'(s_FreezeCount), 0);
    chk("async_ctl", ctl(), 32'b0001111);
    idle(); tick();
    reset = 1'b1; #1;
    chk("release_ctl", ctl(), 32'b1100000);
    tick();
    chk("release_state", 32'(State), 0);
    chk("release_freeze", 32'(FreezeCount), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The module SHALL have parameter CNT_WIDTH, default 16, which sets the width of each event counter.
REQ-002 The module SHALL have these ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt.
- EX_MemRead  in  1  load in EX.
- EX_WriteRegister  in  5  destination register of the instruction in EX.
- MEM_BranchTaken  in  1  branch resolved taken in MEM.
- WB_Jump  in  1  jump redirect in WB.
- MemBusy  in  1  data memory wait request.
- ClearCounters  in  1  synchronous counter clear.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register load enable.
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush  out  1 each  bubble insert into the named register.
- Freeze  out  1  hold all pipeline registers.
- State  out  2  current FSM state.
- StallCount, FlushCount, FreezeCount  out  CNT_WIDTH each  saturating event counters.

Function
REQ-003 The FSM SHALL have four states, encoded on State as RUN=0, STALL=1, FLUSH=2, FREEZE=3.
REQ-004 A load-use hazard SHALL be raised when all of these hold: EX_MemRead=1, EX_WriteRegister!=0, and either EX_WriteRegister==ID_Rs or (ID_UsesRt=1 and EX_WriteRegister==ID_Rt).
REQ-005 Hazard detection SHALL be suppressed when State is STALL or FLUSH.
REQ-006 Actions SHALL be chosen each cycle in this priority order: MemBusy, then WB_Jump, then MEM_BranchTaken, then load-use, then none.
REQ-007 All outputs except State and the counters SHALL be combinational from the inputs and State, taking effect in the same cycle.
REQ-008 FREEZE action (MemBusy=1):
- Freeze=1, PCWrite=0, IF_ID_Write=0, all flushes 0.
- Next state FREEZE.
- Any pending redirect or stall is deferred; MEM_BranchTaken and WB_Jump are re-evaluated after MemBusy falls.
REQ-009 Jump action (WB_Jump=1, MemBusy=0):
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush and MEM_WB_Flush all 1.
- PCWrite=1, IF_ID_Write=1.
- Next state FLUSH.
REQ-010 Branch action (MEM_BranchTaken=1, no higher priority):
- IF_ID_Flush, ID_EX_Flush and EX_MEM_Flush 1; MEM_WB_Flush=0.
- PCWrite=1, IF_ID_Write=1.
- Next state FLUSH.
REQ-011 Stall action (load-use, no higher priority):
- PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, other flushes 0.
- Next state STALL.
REQ-012 None action: PCWrite=1, IF_ID_Write=1, Freeze=0, all flushes 0, next state RUN.
REQ-013 STALL and FLUSH SHALL each last exactly one cycle unless a higher-priority action occurs in that cycle.
REQ-014 Counters SHALL update on the clock edge:
- StallCount +1 per stall action.
- FlushCount +1 per jump or branch action.
- FreezeCount +1 per freeze cycle.
REQ-015 Each counter SHALL saturate at 2^CNT_WIDTH-1 and SHALL NOT wrap.
REQ-016 ClearCounters=1 SHALL zero all counters on the next edge and SHALL take priority over a simultaneous increment.
REQ-017 When a branch or jump coincides with a load-use hazard, only the redirect SHALL occur; StallCount SHALL be unchanged.
REQ-018 When WB_Jump and MEM_BranchTaken coincide, only the jump SHALL be acted on, and FlushCount SHALL increase by 1.

Reset
REQ-019 reset=0 SHALL asynchronously force State=RUN and all counters to 0.
REQ-020 While reset=0, outputs SHALL be: PCWrite=0, IF_ID_Write=0, Freeze=0, all four flushes 1.
REQ-021 Assertion of reset mid-STALL, mid-FLUSH or mid-FREEZE SHALL abandon that action immediately.
REQ-022 After reset deasserts, the first edge SHALL evaluate from state RUN.

Verification
REQ-023 Load-use: EX_MemRead=1, EX_WriteRegister=8, ID_Rs=8 -> PCWrite=0, ID_EX_Flush=1 for one cycle; State=STALL on the next cycle; StallCount=1.
REQ-024 rt gating: EX_WriteRegister=9, ID_Rt=9 with ID_UsesRt=0 -> no stall; the same with ID_UsesRt=1 -> stall. EX_WriteRegister=0 with ID_Rs=0 -> no stall.
REQ-025 Branch during load-use: MEM_BranchTaken=1 together with a load-use hazard -> IF_ID_Flush, ID_EX_Flush and EX_MEM_Flush =1, PCWrite=1, FlushCount=1, StallCount=0, State=FLUSH.
REQ-026 Freeze deferral: MemBusy=1 for 3 cycles while WB_Jump=1 -> Freeze=1, no flush, FreezeCount=3; the cycle after MemBusy falls -> all four flushes 1.
REQ-027 Saturation and clear: with CNT_WIDTH=2, 5 stall actions -> StallCount=3; ClearCounters=1 together with a stall -> StallCount=0.
REQ-028 Reset mid-FREEZE: reset=0 asynchronously -> State=0 and counters 0 without waiting for a clock edge; after release with no hazard -> RUN outputs.
